// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, jump-field width, PC increment and redirect kinds.
package cpu_types_pkg;

  localparam int ADDR_W = 26;

  typedef logic [31:0] word_t;

  localparam word_t PC_INCR = 32'd4;

  typedef enum logic [1:0] {REDIR_NONE, REDIR_BR, REDIR_J, REDIR_JR} pc_redir_t;

  function automatic word_t ctx_reset_pc(input word_t base, input word_t stride, input int ctx);
    return base + stride * word_t'(ctx);
  endfunction

endpackage

// File: rtl/pc_rr_arbiter.sv
// Round-robin selector: finds the next live context after the current pointer, wrapping around.
module pc_rr_arbiter #(
  parameter  int NCTX = 2,
  localparam int CTXW = (NCTX > 1) ? $clog2(NCTX) : 1
) (
  input  logic [CTXW-1:0] ptr_i,
  input  logic [NCTX-1:0] live_i,
  output logic [CTXW-1:0] next_ptr_o,
  output logic            any_live_o
);

  logic found;

  // Search offsets 1..NCTX so the current context is only kept when it is the sole live one.
  always_comb begin
    next_ptr_o = ptr_i;
    found      = 1'b0;
    for (int i = 1; i <= NCTX; i++) begin
      for (int c = 0; c < NCTX; c++) begin
        if (!found && (c == (int'(ptr_i) + i) % NCTX) && live_i[c]) begin
          next_ptr_o = CTXW'(c);
          found      = 1'b1;
        end
      end
    end
  end

  assign any_live_o = |live_i;

endmodule

// File: rtl/pc_multictx.sv
// Multi-context fetch PC with round-robin context selection, prioritised redirects and sticky halts.
// Optional jr alignment fault (halt + misalign pulse) is built when PC_ALIGN_CHK_EN is defined.
module pc_multictx
  import cpu_types_pkg::*;
#(
  parameter  int    NCTX       = 2,
  parameter  word_t RESET_PC   = 32'h0000_0000,
  parameter  word_t CTX_STRIDE = 32'h0000_1000,
  localparam int    CTXW       = (NCTX > 1) ? $clog2(NCTX) : 1
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              pcEN,
  input  logic [NCTX-1:0]   halt,
  input  logic [CTXW-1:0]   redir_ctx,
  input  logic [31:0]       npc,
  input  logic              branchmux,
  input  logic [31:0]       immext,
  input  logic              jumpmux,
  input  logic [ADDR_W-1:0] imm26,
  input  logic              jrmux,
  input  logic [31:0]       jr_target,
  output logic [31:0]       imemaddr,
  output logic [CTXW-1:0]   fetch_ctx,
  output logic              fetch_vld,
  output logic [NCTX-1:0]   halted
`ifdef PC_ALIGN_CHK_EN
  ,
  output logic              misalign
`endif
);

  word_t           pc_q [NCTX];
  word_t           pc_d [NCTX];
  logic [NCTX-1:0] halted_q, halted_d;
  logic [CTXW-1:0] ptr_q, ptr_d, arb_next;
  logic [NCTX-1:0] redir_hit;
  logic            any_live, advance, move, bad_jr;
  pc_redir_t       redir_sel;
  word_t           redir_target;

  assign imemaddr  = pc_q[ptr_q];
  assign fetch_ctx = ptr_q;
  assign fetch_vld = ~halted_q[ptr_q];
  assign halted    = halted_q;
  assign advance   = pcEN & fetch_vld;

  always_comb begin
    redir_sel = REDIR_NONE;
    if (jrmux)          redir_sel = REDIR_JR;
    else if (jumpmux)   redir_sel = REDIR_J;
    else if (branchmux) redir_sel = REDIR_BR;

    case (redir_sel)
      REDIR_BR: redir_target = npc + (immext << 2);
      REDIR_J:  redir_target = {npc[31:28], imm26, 2'b00};
      REDIR_JR: redir_target = jr_target & ~word_t'(32'd3);
      default:  redir_target = npc;
    endcase
  end

`ifdef PC_ALIGN_CHK_EN
  assign bad_jr = (redir_sel == REDIR_JR) && (jr_target[1:0] != 2'b00);
`else
  assign bad_jr = 1'b0;
`endif

  // A redirect to a live context overrides that context's +4; a faulting jr freezes it instead.
  always_comb begin
    for (int c = 0; c < NCTX; c++) begin
      redir_hit[c] = (redir_sel != REDIR_NONE) && (redir_ctx == CTXW'(c)) && !halted_q[c];
      halted_d[c]  = halted_q[c] | halt[c] | (redir_hit[c] & bad_jr);
      pc_d[c]      = pc_q[c];
      if (redir_hit[c]) begin
        if (!bad_jr) pc_d[c] = redir_target;
      end else if (advance && (ptr_q == CTXW'(c))) begin
        pc_d[c] = pc_q[c] + PC_INCR;
      end
    end
  end

  pc_rr_arbiter #(.NCTX(NCTX)) u_arb (
    .ptr_i      (ptr_q),
    .live_i     (~halted_d),
    .next_ptr_o (arb_next),
    .any_live_o (any_live)
  );

  assign move  = advance | halted_d[ptr_q];
  assign ptr_d = (move && any_live) ? arb_next : ptr_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int c = 0; c < NCTX; c++) pc_q[c] <= ctx_reset_pc(RESET_PC, CTX_STRIDE, c);
      halted_q <= '0;
      ptr_q    <= '0;
    end else begin
      for (int c = 0; c < NCTX; c++) pc_q[c] <= pc_d[c];
      halted_q <= halted_d;
      ptr_q    <= ptr_d;
    end
  end

`ifdef PC_ALIGN_CHK_EN
  logic misalign_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) misalign_q <= 1'b0;
    else       misalign_q <= |(redir_hit & {NCTX{bad_jr}});
  end

  assign misalign = misalign_q;
`endif

endmodule

// File: tb/tb_pc_multictx.sv
// Directed bench for pc_multictx: a two-context reference model checked every cycle, plus literal
// expectations and a single-context instance for PC wrap. Honours PC_ALIGN_CHK_EN when defined.
module tb_pc_multictx;

  logic        clock = 1'b0;
  logic        resetN;
  logic        pcEn, branchMux, jumpMux, jrMux;
  logic [1:0]  haltReq;
  logic [0:0]  redirCtx;
  logic [31:0] npcIn, immExt, jrTarget;
  logic [25:0] imm26In;
  logic [31:0] imemAddr;
  logic [0:0]  fetchCtx;
  logic        fetchVld;
  logic [1:0]  haltedOut;

  logic        pcEnOne, jumpMuxOne;
  logic [0:0]  haltOne, redirCtxOne, fetchCtxOne, haltedOne;
  logic        fetchVldOne;
  logic [31:0] imemAddrOne;
`ifdef PC_ALIGN_CHK_EN
  logic        misalignOut, misalignOne;
`endif

  int checkCount = 0;
  int errorCount = 0;
  bit modelOn = 1'b0;

  logic [31:0] mPc [2];
  logic [1:0]  mHalt;
  int          mPtr;
  bit          mMis;

  always #5 clock = ~clock;

  pc_multictx #(.NCTX(2), .RESET_PC(32'h0), .CTX_STRIDE(32'h1000)) dut (
    .CLK(clock), .nRST(resetN), .pcEN(pcEn), .halt(haltReq), .redir_ctx(redirCtx),
    .npc(npcIn), .branchmux(branchMux), .immext(immExt), .jumpmux(jumpMux), .imm26(imm26In),
    .jrmux(jrMux), .jr_target(jrTarget), .imemaddr(imemAddr), .fetch_ctx(fetchCtx),
    .fetch_vld(fetchVld), .halted(haltedOut)
`ifdef PC_ALIGN_CHK_EN
    , .misalign(misalignOut)
`endif
  );

  pc_multictx #(.NCTX(1), .RESET_PC(32'hFFFF_FFFC), .CTX_STRIDE(32'h1000)) dutOne (
    .CLK(clock), .nRST(resetN), .pcEN(pcEnOne), .halt(haltOne), .redir_ctx(redirCtxOne),
    .npc(npcIn), .branchmux(1'b0), .immext(immExt), .jumpmux(jumpMuxOne), .imm26(imm26In),
    .jrmux(1'b0), .jr_target(jrTarget), .imemaddr(imemAddrOne), .fetch_ctx(fetchCtxOne),
    .fetch_vld(fetchVldOne), .halted(haltedOne)
`ifdef PC_ALIGN_CHK_EN
    , .misalign(misalignOne)
`endif
  );

  task automatic compareVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference behaviour: one step of the context machine from its rules, using plain arithmetic.
  task automatic modelStep();
    int          kind, rc, cur, cand;
    logic [31:0] tgt;
    logic [1:0]  nh;
    bit          adv, hit, fault;
    mMis  = 1'b0;
    cur   = mPtr;
    rc    = int'(redirCtx);
    adv   = pcEn && !mHalt[cur];
    nh    = mHalt | haltReq;
    kind  = jrMux ? 3 : (jumpMux ? 2 : (branchMux ? 1 : 0));
    tgt   = 32'h0;
    hit   = 1'b0;
    fault = 1'b0;
    case (kind)
      1: tgt = npcIn + immExt * 32'd4;
      2: tgt = (npcIn & 32'hF000_0000) + {6'd0, imm26In} * 32'd4;
      3: tgt = jrTarget - (jrTarget % 32'd4);
      default: tgt = 32'h0;
    endcase
    if (kind != 0 && rc < 2 && !mHalt[rc]) begin
      hit = 1'b1;
`ifdef PC_ALIGN_CHK_EN
      fault = (kind == 3) && (jrTarget % 32'd4 != 0);
`endif
      if (fault) begin
        nh[rc] = 1'b1;
        mMis   = 1'b1;
      end else begin
        mPc[rc] = tgt;
      end
    end
    if (adv && !(hit && rc == cur)) mPc[cur] = mPc[cur] + 32'd4;
    if (adv || nh[cur]) begin
      for (int k = 1; k <= 2; k++) begin
        cand = (cur + k) % 2;
        if (!nh[cand]) begin
          mPtr = cand;
          break;
        end
      end
    end
    mHalt = nh;
  endtask

  always @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      mPc[0] = 32'h0;
      mPc[1] = 32'h1000;
      mHalt  = 2'b00;
      mPtr   = 0;
      mMis   = 1'b0;
    end else begin
      modelStep();
    end
  end

  task automatic checkOutput();
    compareVal("model_imemaddr", imemAddr, mPc[mPtr]);
    compareVal("model_fetch_ctx", {31'd0, fetchCtx}, 32'(mPtr));
    compareVal("model_fetch_vld", {31'd0, fetchVld}, {31'd0, !mHalt[mPtr]});
    compareVal("model_halted", {30'd0, haltedOut}, {30'd0, mHalt});
`ifdef PC_ALIGN_CHK_EN
    compareVal("model_misalign", {31'd0, misalignOut}, {31'd0, mMis});
`endif
  endtask

  always @(negedge clock) begin
    if (resetN && modelOn) checkOutput();
  end

  // Drives one cycle of inputs and returns at the following falling edge.
  task automatic applyStimulus(input logic en, input logic [1:0] hlt, input logic ctx,
                               input logic br, input logic jm, input logic jr,
                               input logic [31:0] npcV, input logic [31:0] immV,
                               input logic [25:0] i26V, input logic [31:0] jrtV);
    pcEn      = en;
    haltReq   = hlt;
    redirCtx  = ctx;
    branchMux = br;
    jumpMux   = jm;
    jrMux     = jr;
    npcIn     = npcV;
    immExt    = immV;
    imm26In   = i26V;
    jrTarget  = jrtV;
    @(negedge clock);
  endtask

  task automatic idle(input logic en);
    applyStimulus(en, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 26'h0, 32'h0);
  endtask

  initial begin
    resetN = 1'b0;
    pcEn = 1'b0; haltReq = 2'b00; redirCtx = 1'b0; branchMux = 1'b0; jumpMux = 1'b0; jrMux = 1'b0;
    npcIn = 32'h0; immExt = 32'h0; imm26In = 26'h0; jrTarget = 32'h0;
    pcEnOne = 1'b0; jumpMuxOne = 1'b0; haltOne = 1'b0; redirCtxOne = 1'b0;
    #12;
    compareVal("reset_imemaddr", imemAddr, 32'h0);
    compareVal("reset_fetch_ctx", {31'd0, fetchCtx}, 32'd0);
    compareVal("reset_fetch_vld", {31'd0, fetchVld}, 32'd1);
    compareVal("reset_halted", {30'd0, haltedOut}, 32'd0);
    compareVal("reset_one_imemaddr", imemAddrOne, 32'hFFFF_FFFC);
    resetN  = 1'b1;
    modelOn = 1'b1;

    // Round-robin advance across both contexts; single-context instance wraps past 2^32.
    pcEnOne = 1'b1;
    idle(1'b1);
    compareVal("rr1_imemaddr", imemAddr, 32'h1000);
    compareVal("rr1_fetch_ctx", {31'd0, fetchCtx}, 32'd1);
    compareVal("wrap_one_imemaddr", imemAddrOne, 32'h0);
    idle(1'b1);
    compareVal("rr2_imemaddr", imemAddr, 32'h4);
    compareVal("one_after_wrap", imemAddrOne, 32'h4);
    pcEnOne = 1'b0;
    idle(1'b1);
    compareVal("rr3_imemaddr", imemAddr, 32'h1004);
    compareVal("rr3_fetch_ctx", {31'd0, fetchCtx}, 32'd1);

    // Jump beats branch on ctx0; the single-context instance ignores an out-of-range redirect.
    jumpMuxOne  = 1'b1;
    redirCtxOne = 1'b1;
    applyStimulus(1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 32'h40, 32'hFFFF_FFFE, 26'h10, 32'h0);
    jumpMuxOne  = 1'b0;
    redirCtxOne = 1'b0;
    compareVal("prio_hold_imemaddr", imemAddr, 32'h1004);
    compareVal("one_bad_ctx_ignored", imemAddrOne, 32'h4);
    idle(1'b1);
    compareVal("prio_jump_pc0", imemAddr, 32'h40);

    // Branch to ctx1 while stalled leaves ctx0 untouched.
    applyStimulus(1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 32'h1010, 32'd3, 26'h0, 32'h0);
    compareVal("branch_pc0_unchanged", imemAddr, 32'h40);
    idle(1'b1);
    compareVal("branch_pc1", imemAddr, 32'h101C);

    // Redirect and advance on the same context: target taken, no +4, pointer still moves.
    applyStimulus(1'b1, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 32'h1020, 32'h0, 26'h100, 32'h0);
    compareVal("redir_adv_ctx", {31'd0, fetchCtx}, 32'd0);
    compareVal("redir_adv_pc0", imemAddr, 32'h44);
    idle(1'b1);
    compareVal("redir_adv_pc1", imemAddr, 32'h400);

    // Misaligned jr to ctx0.
    applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 26'h0, 32'h203);
`ifdef PC_ALIGN_CHK_EN
    compareVal("jr_misalign_pulse", {31'd0, misalignOut}, 32'd1);
    compareVal("jr_fault_halted", {30'd0, haltedOut}, 32'd1);
    idle(1'b1);
    compareVal("jr_misalign_clear", {31'd0, misalignOut}, 32'd0);
    compareVal("jr_fault_ctx1_only", imemAddr, 32'h404);
`else
    idle(1'b1);
    compareVal("jr_aligned_pc0", imemAddr, 32'h200);
`endif

    // Asynchronous reset mid-run discards a pending redirect.
    jumpMux  = 1'b1;
    redirCtx = 1'b0;
    imm26In  = 26'h3F;
    #2 resetN = 1'b0;
    #1;
    compareVal("midrst_imemaddr", imemAddr, 32'h0);
    compareVal("midrst_fetch_ctx", {31'd0, fetchCtx}, 32'd0);
    compareVal("midrst_fetch_vld", {31'd0, fetchVld}, 32'd1);
    compareVal("midrst_halted", {30'd0, haltedOut}, 32'd0);
    @(posedge clock);
    #1;
    compareVal("midrst_hold_imemaddr", imemAddr, 32'h0);
    @(negedge clock);
    jumpMux = 1'b0;
    imm26In = 26'h0;
    resetN  = 1'b1;

    // Halt ctx1 while it is fetched, then halt ctx0 so nothing is live.
    idle(1'b1);
    compareVal("halt_pre_ctx", {31'd0, fetchCtx}, 32'd1);
    applyStimulus(1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 26'h0, 32'h0);
    compareVal("halt1_halted", {30'd0, haltedOut}, 32'd2);
    compareVal("halt1_ctx", {31'd0, fetchCtx}, 32'd0);
    compareVal("halt1_imemaddr", imemAddr, 32'h4);
    idle(1'b1);
    idle(1'b1);
    compareVal("halt1_only_ctx0", {31'd0, fetchCtx}, 32'd0);
    compareVal("halt1_only_ctx0_pc", imemAddr, 32'hC);
    applyStimulus(1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 26'h0, 32'h0);
    compareVal("allhalt_vld", {31'd0, fetchVld}, 32'd0);
    compareVal("allhalt_halted", {30'd0, haltedOut}, 32'd3);
    compareVal("allhalt_imemaddr", imemAddr, 32'hC);
    applyStimulus(1'b1, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 32'h2000, 32'd1, 26'h0, 32'h0);
    idle(1'b1);
    compareVal("allhalt_frozen_pc", imemAddr, 32'hC);
    compareVal("allhalt_frozen_ctx", {31'd0, fetchCtx}, 32'd0);
    compareVal("allhalt_sticky", {30'd0, haltedOut}, 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
